// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - 5-stage pipeline sequencer: hazard merge, memory-wait freeze, timeout halt.
// Optional statistics counters are enabled by defining PIPE_CTRL_STATS_EN.
module pipeline_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use_stall,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             id_ex_we,
  output logic             ex_mem_we,
  output logic             mem_wb_we,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             halted,
  output logic [1:0]       state_o
`ifdef PIPE_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  state_t     state_q;
  logic [7:0] wait_cnt_q;
  logic       halted_q;

  logic       mem_pending;
  logic       ack_eff;
  logic [4:0] we;
  logic [1:0] flush;

  assign mem_pending = dmem_req & ~dmem_ack;
  // A request dropped while waiting is a protocol error; treat it as completion.
  assign ack_eff     = dmem_ack | ~dmem_req;

  always_comb begin
    we    = 5'b00000;
    flush = 2'b00;
    if (!rst) begin
      unique case (state_q)
        RUN: begin
          if (!mem_pending) begin
            if (branch_taken) begin
              we    = 5'b11111;
              flush = 2'b11;
            end else if (load_use_stall) begin
              we    = 5'b00111;
              flush = 2'b01;
            end else begin
              we    = 5'b11111;
            end
          end
        end
        MEM_WAIT: begin
          // ID/EX were frozen, so their hazard inputs still describe the current instructions.
          if (ack_eff) begin
            if (branch_taken) begin
              we    = 5'b11111;
              flush = 2'b11;
            end else if (load_use_stall) begin
              we    = 5'b00111;
              flush = 2'b01;
            end else begin
              we    = 5'b11111;
            end
          end
        end
        default: begin
          we    = 5'b00000;
          flush = 2'b00;
        end
      endcase
    end
  end

  assign {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = we;
  assign {if_id_flush, id_ex_flush} = flush;
  assign halted  = halted_q;
  assign state_o = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= 8'd0;
      halted_q   <= 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (mem_pending) begin
            state_q    <= MEM_WAIT;
            wait_cnt_q <= 8'd1;
          end
        end
        MEM_WAIT: begin
          if (ack_eff) begin
            state_q    <= RUN;
            wait_cnt_q <= 8'd0;
          end else begin
            if (wait_cnt_q == 8'(MEM_TIMEOUT)) begin
              state_q  <= HALT;
              halted_q <= 1'b1;
            end
            if (wait_cnt_q != 8'hFF) begin
              wait_cnt_q <= wait_cnt_q + 8'd1;
            end
          end
        end
        HALT: begin
          halted_q <= 1'b1;
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

`ifdef PIPE_CTRL_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (state_q != HALT && !pc_we && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (if_id_flush && flush_cnt_q != '1) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - self-checking bench for pipeline_ctrl against a behavioural model.
module tb_pipeline_ctrl;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_use_stall = 1'b0;
  logic       branch_taken = 1'b0;
  logic       dmem_req = 1'b0;
  logic       dmem_ack = 1'b0;
  logic       pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic       if_id_flush, id_ex_flush, halted;
  logic [1:0] state_o;
`ifdef PIPE_CTRL_STATS_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  pipeline_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .load_use_stall(load_use_stall), .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we),
    .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .halted(halted), .state_o(state_o)
`ifdef PIPE_CTRL_STATS_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: whether the core is stuck, waiting on memory, and for how many cycles so far.
  bit          m_halt = 0;
  bit          m_waiting = 0;
  int          m_waited = 0;
  longint      m_stalls = 0;
  longint      m_flushes = 0;

  logic [6:0] obs;
  assign obs = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush};

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // Expected {pc,if_id,id_ex,ex_mem,mem_wb,if_flush,id_flush}.
  function automatic logic [6:0] model_out(input bit lus, input bit br, input bit req, input bit ack);
    if (rst) return 7'b0;
    if (m_halt || (req && !ack)) return 7'b0;   // frozen: halted or memory still busy
    if (br) return 7'b1111111;
    if (lus) return 7'b0011101;
    return 7'b1111100;
  endfunction

  function automatic logic [1:0] model_state();
    if (m_halt) return 2'd2;
    if (m_waiting) return 2'd1;
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_halt = 0; m_waiting = 0; m_waited = 0; m_stalls = 0; m_flushes = 0;
  endtask

  task automatic check_now(input string tag, input logic [6:0] e);
    chk({tag, ".out"}, 32'(obs), 32'(e));
    chk({tag, ".state"}, 32'(state_o), 32'(model_state()));
    chk({tag, ".halted"}, 32'(halted), 32'(m_halt));
`ifdef PIPE_CTRL_STATS_EN
    chk({tag, ".stall_cnt"}, stall_cnt, 32'(m_stalls));
    chk({tag, ".flush_cnt"}, flush_cnt, 32'(m_flushes));
`endif
  endtask

  task automatic cycle(input string tag, input bit lus, input bit br, input bit req, input bit ack);
    logic [6:0] e;
    bit busy;
    load_use_stall = lus; branch_taken = br; dmem_req = req; dmem_ack = ack;
    #2;
    e = model_out(lus, br, req, ack);
    check_now(tag, e);
    busy = req && !ack;
    @(posedge clk);
    #1;
    if (!m_halt && !e[6]) m_stalls++;
    if (e[1]) m_flushes++;
    if (m_halt) begin
    end else if (m_waiting) begin
      if (!busy) begin
        m_waiting = 0; m_waited = 0;
      end else if (m_waited == TO) begin
        m_halt = 1; m_waiting = 0;
      end else begin
        m_waited++;
      end
    end else if (busy) begin
      m_waiting = 1; m_waited = 1;
    end
  endtask

  // Asynchronous reset pulse raised mid-cycle, checked before any clock edge.
  task automatic async_reset(input string tag);
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_now({tag, ".async"}, 7'b0);
    @(posedge clk);
    #1;
    check_now({tag, ".held"}, 7'b0);
    rst = 1'b0;
  endtask

  initial begin
    bit lus, br, req, ack;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_now("in_reset", 7'b0);
    rst = 1'b0;

    cycle("first", 0, 0, 0, 0);
    chk("first.all_adv", 32'(obs), 32'h7C);

    cycle("lus", 1, 0, 0, 0);
    cycle("lus.after", 0, 0, 0, 0);
    cycle("br_lus", 1, 1, 0, 0);
    cycle("single_mem", 0, 0, 1, 1);

    for (int i = 0; i < 3; i++) cycle("memwait", 0, 1, 1, 0);
    cycle("memwait.ack", 0, 1, 1, 1);
    chk("memwait.ack_flush", 32'(obs), 32'h7F);
    cycle("memwait.after", 0, 0, 0, 0);
    chk("memwait.run", 32'(state_o), 32'd0);

    cycle("mw_lus.enter", 1, 0, 1, 0);
    cycle("mw_lus.ack", 1, 0, 1, 1);

    cycle("drop.enter", 0, 0, 1, 0);
    cycle("drop.req0", 0, 1, 0, 0);

    for (int i = 0; i < TO + 1; i++) cycle("timeout", 0, 0, 1, 0);
    chk("timeout.halted", 32'(halted), 32'd1);
    chk("timeout.state", 32'(state_o), 32'd2);
    cycle("halt.ack", 0, 0, 1, 1);
    cycle("halt.idle", 1, 1, 0, 0);
    async_reset("halt_rst");
    cycle("halt_rst.run", 0, 0, 0, 0);

    cycle("mid.enter", 0, 0, 1, 0);
    cycle("mid.wait", 0, 0, 1, 0);
    async_reset("mid_rst");
    cycle("mid_rst.run", 0, 0, 0, 0);

    for (int i = 0; i < 500; i++) begin
      lus = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 4) == 0);
      req = ($urandom_range(0, 1) == 1);
      ack = ($urandom_range(0, 9) < 3);
      cycle("rand", lus, br, req, ack);
      if ((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 59) == 0)
        async_reset("rand_rst");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
